// File: rtl/coax_rx_frontend.sv
// Receive front end ahead of coax_buffered_rx: per-channel synchronisers, majority glitch filter,
// source select, configuration-change receiver reset, activity stretcher and receive-error counter.
module coax_rx_frontend #(
    parameter int CHANNELS          = 1,
    parameter int SEL_WIDTH         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    parameter int SYNC_STAGES       = 2,
    parameter int FILTER_TAPS       = 3,
    parameter int RESET_CYCLES      = 16,
    parameter int ACTIVITY_STRETCH  = 1900000,
    parameter int ERROR_COUNT_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [CHANNELS-1:0]          rx_in,
    input  logic                         tx,
    input  logic                         rx_enable,
    input  logic                         loopback,
    input  logic [SEL_WIDTH-1:0]         channel_select,
    output logic                         rx_out,
    output logic                         rx_reset,
    input  logic                         rx_active,
    input  logic                         rx_error,
    output logic                         activity_led,
    output logic [ERROR_COUNT_WIDTH-1:0] error_count,
    input  logic                         error_count_clear,
    output logic                         dbg_seq_state
);

    localparam int CFG_W = SEL_WIDTH + 2;
    localparam int RST_W = $clog2(RESET_CYCLES + 1);
    localparam int ACT_W = $clog2(ACTIVITY_STRETCH + 1);
    localparam logic [RST_W-1:0] RST_LOAD = RST_W'(RESET_CYCLES);
    localparam logic [ACT_W-1:0] ACT_LOAD = ACT_W'(ACTIVITY_STRETCH);

    typedef enum logic {
        SEQ_IDLE      = 1'b0,
        SEQ_RESETTING = 1'b1
    } seq_state_t;

    // Handshake-free block: every input is sampled each clock; outputs are registered levels.

    // ------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sync [CHANNELS];
    logic [CHANNELS-1:0]    w_sync_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_sync[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_sync[c] <= {r_sync[c][SYNC_STAGES-2:0], rx_in[c]};
            end
        end
    end

    genvar g_c;
    generate
        for (g_c = 0; g_c < CHANNELS; g_c++) begin : g_sync_out
            assign w_sync_out[g_c] = r_sync[g_c][SYNC_STAGES-1];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Configuration register and receiver-reset sequencer
    // ------------------------------------------------------------------
    logic [CFG_W-1:0]     r_cfg;
    logic [CFG_W-1:0]     w_cfg_live;
    logic                 w_cfg_change;
    seq_state_t           r_seq_state;
    seq_state_t           w_seq_next;
    logic [RST_W-1:0]     r_rst_cnt;
    logic [RST_W-1:0]     w_rst_cnt_next;
    logic                 r_rx_reset;
    logic                 w_cfg_enable;
    logic                 w_cfg_loopback;
    logic [SEL_WIDTH-1:0] w_cfg_sel;

    assign w_cfg_live     = {rx_enable, loopback, channel_select};
    assign w_cfg_change   = (w_cfg_live != r_cfg);
    assign w_cfg_enable   = r_cfg[CFG_W-1];
    assign w_cfg_loopback = r_cfg[CFG_W-2];
    assign w_cfg_sel      = r_cfg[SEL_WIDTH-1:0];

    // A change while already resetting restarts the full pulse rather than extending it.
    always_comb begin
        w_seq_next     = r_seq_state;
        w_rst_cnt_next = r_rst_cnt;
        if (w_cfg_change) begin
            w_seq_next     = SEQ_RESETTING;
            w_rst_cnt_next = RST_LOAD;
        end else begin
            case (r_seq_state)
                SEQ_IDLE: begin
                    w_rst_cnt_next = '0;
                end
                SEQ_RESETTING: begin
                    if (r_rst_cnt <= RST_W'(1)) begin
                        w_rst_cnt_next = '0;
                        w_seq_next     = SEQ_IDLE;
                    end else begin
                        w_rst_cnt_next = r_rst_cnt - RST_W'(1);
                    end
                end
                default: begin
                    w_seq_next     = SEQ_IDLE;
                    w_rst_cnt_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_seq_state <= SEQ_RESETTING;
            r_rst_cnt   <= RST_LOAD;
            r_cfg       <= w_cfg_live;
            r_rx_reset  <= 1'b1;
        end else begin
            r_seq_state <= w_seq_next;
            r_rst_cnt   <= w_rst_cnt_next;
            r_cfg       <= w_cfg_live;
            r_rx_reset  <= (r_seq_state == SEQ_RESETTING);
        end
    end

    assign rx_reset      = r_rx_reset;
    assign dbg_seq_state = (r_seq_state == SEQ_RESETTING);

    // ------------------------------------------------------------------
    // Channel mux and majority filter
    // ------------------------------------------------------------------
    logic                   w_sel_bit;
    logic [FILTER_TAPS-1:0] w_window;
    logic                   r_filt;

    // Out-of-range selects fall through to channel 0.
    always_comb begin
        w_sel_bit = w_sync_out[0];
        for (int c = 1; c < CHANNELS; c++) begin
            if (w_cfg_sel == SEL_WIDTH'(c)) begin
                w_sel_bit = w_sync_out[c];
            end
        end
    end

    // The last synchroniser flop is the newest window tap, so only FILTER_TAPS-1 extra flops are needed.
    generate
        if (FILTER_TAPS == 1) begin : g_nofilt
            assign w_window = w_sel_bit;
        end else begin : g_filt
            logic [FILTER_TAPS-2:0] r_hist;
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_hist <= '0;
                end else if (FILTER_TAPS == 2) begin
                    r_hist <= w_sel_bit;
                end else begin
                    r_hist <= {r_hist[FILTER_TAPS-3:0], w_sel_bit};
                end
            end
            assign w_window = {r_hist, w_sel_bit};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_filt <= 1'b0;
        end else begin
            r_filt <= ($countones(w_window) > (FILTER_TAPS / 2));
        end
    end

    // ------------------------------------------------------------------
    // Source select and output gating
    // ------------------------------------------------------------------
    logic w_src;
    logic r_rx_out;

    always_comb begin
        w_src = 1'b0;
        if (w_cfg_enable) begin
            w_src = w_cfg_loopback ? tx : r_filt;
        end
    end

    // Gated with the same term that drives r_rx_reset, so rx_out is low on exactly those cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_out <= 1'b0;
        end else begin
            r_rx_out <= (r_seq_state == SEQ_RESETTING) ? 1'b0 : w_src;
        end
    end

    assign rx_out = r_rx_out;

    // ------------------------------------------------------------------
    // Activity stretcher
    // ------------------------------------------------------------------
    logic [ACT_W-1:0] r_act_cnt;
    logic [ACT_W-1:0] w_act_next;
    logic             r_led;

    always_comb begin
        w_act_next = r_act_cnt;
        if (rx_active) begin
            w_act_next = ACT_LOAD;
        end else if (r_act_cnt != '0) begin
            w_act_next = r_act_cnt - ACT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_act_cnt <= '0;
            r_led     <= 1'b0;
        end else begin
            r_act_cnt <= w_act_next;
            r_led     <= (w_act_next != '0);
        end
    end

    assign activity_led = r_led;

    // ------------------------------------------------------------------
    // Saturating receive-error counter
    // ------------------------------------------------------------------
    logic                         r_err_prev;
    logic                         r_err_edge;
    logic [ERROR_COUNT_WIDTH-1:0] r_err_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_prev <= 1'b0;
            r_err_edge <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            r_err_prev <= rx_error;
            r_err_edge <= rx_error & ~r_err_prev & ~r_rx_reset;
            if (error_count_clear) begin
                r_err_cnt <= '0;
            end else if (r_err_edge && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + ERROR_COUNT_WIDTH'(1);
            end
        end
    end

    assign error_count = r_err_cnt;

endmodule

// File: tb/tb_coax_rx_frontend.sv
// Self-checking bench for coax_rx_frontend: scenario tasks compare DUT outputs against a
// cycle-level behavioural model built from delay-line/majority and event-age rules.
module tb_coax_rx_frontend;

    localparam int CH  = 4;
    localparam int SW  = 3;
    localparam int S   = 2;
    localparam int FT  = 3;
    localparam int R   = 16;
    localparam int AS  = 10;
    localparam int ECW = 2;

    // ---------------- clock / reset / DUT ----------------
    logic           clk = 1'b0;
    logic           reset;
    logic [CH-1:0]  rx_in;
    logic           tx;
    logic           rx_enable;
    logic           loopback;
    logic [SW-1:0]  channel_select;
    logic           rx_out;
    logic           rx_reset;
    logic           rx_active;
    logic           rx_error;
    logic           activity_led;
    logic [ECW-1:0] error_count;
    logic           error_count_clear;
    logic           dbg_seq_state;

    always #5 clk = ~clk;

    coax_rx_frontend #(
        .CHANNELS(CH), .SEL_WIDTH(SW), .SYNC_STAGES(S), .FILTER_TAPS(FT),
        .RESET_CYCLES(R), .ACTIVITY_STRETCH(AS), .ERROR_COUNT_WIDTH(ECW)
    ) dut (
        .clk(clk), .reset(reset), .rx_in(rx_in), .tx(tx), .rx_enable(rx_enable),
        .loopback(loopback), .channel_select(channel_select), .rx_out(rx_out),
        .rx_reset(rx_reset), .rx_active(rx_active), .rx_error(rx_error),
        .activity_led(activity_led), .error_count(error_count),
        .error_count_clear(error_count_clear), .dbg_seq_state(dbg_seq_state)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- reference model ----------------
    // rx_out is the majority of the selected pin's samples taken S+1..S+FT edges ago;
    // rx_reset is high for R edges after the last reset/config event.
    int             cyc      = 0;
    int             last_evt = -1000;
    int             last_act = -1000;
    logic [CH-1:0]  hist [8];
    logic [SW+1:0]  prev_cfg = '0;
    logic           exp_rst  = 1'b1;
    logic           exp_out  = 1'b0;
    logic           exp_led  = 1'b0;
    logic [ECW-1:0] exp_err  = '0;
    logic           det      = 1'b0;
    logic           err_prev = 1'b0;

    always @(posedge clk) begin : model
        logic [SW+1:0] cfg_now;
        logic          rst_before;
        int            ch;
        int            ones;
        cyc++;
        cfg_now = {rx_enable, loopback, channel_select};
        for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = rx_in;
        if (reset) begin
            for (int k = 0; k < 8; k++) hist[k] = '0;
            exp_rst  = 1'b1;
            exp_out  = 1'b0;
            exp_led  = 1'b0;
            exp_err  = '0;
            det      = 1'b0;
            err_prev = 1'b0;
            last_evt = cyc;
            last_act = -1000;
            prev_cfg = cfg_now;
        end else begin
            rst_before = exp_rst;
            exp_rst = ((cyc - last_evt) >= 1) && ((cyc - last_evt) <= R);
            if (cfg_now != prev_cfg) last_evt = cyc;
            ch = (int'(prev_cfg[SW-1:0]) < CH) ? int'(prev_cfg[SW-1:0]) : 0;
            ones = 0;
            for (int j = 0; j < FT; j++) ones += int'(hist[1+S+j][ch]);
            if (exp_rst || !prev_cfg[SW+1]) exp_out = 1'b0;
            else if (prev_cfg[SW])          exp_out = tx;
            else                            exp_out = (ones > FT/2);
            prev_cfg = cfg_now;
            if (rx_active) last_act = cyc;
            exp_led = (cyc - last_act) < AS;
            if (error_count_clear)           exp_err = '0;
            else if (det && exp_err != '1)   exp_err = exp_err + 1'b1;
            det      = rx_error && !err_prev && !rst_before;
            err_prev = rx_error;
        end
    end

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        int hi;
        int k;
        reset = 1'b1;
        rx_in = '0; tx = 1'b0; rx_enable = 1'b1; loopback = 1'b0; channel_select = '0;
        rx_active = 1'b0; rx_error = 1'b0; error_count_clear = 1'b0;
        repeat (4) @(negedge clk);
        total++; if (rx_reset !== 1'b1) begin bad++; $display("FAIL reset_rx_reset got=%0b exp=1", rx_reset); end
        total++; if (rx_out !== 1'b0) begin bad++; $display("FAIL reset_rx_out got=%0b exp=0", rx_out); end
        total++; if (activity_led !== 1'b0) begin bad++; $display("FAIL reset_led got=%0b exp=0", activity_led); end
        total++; if (error_count !== '0) begin bad++; $display("FAIL reset_err_cnt got=%0d exp=0", error_count); end
        reset = 1'b0;
        hi = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (rx_reset === 1'b1) hi++;
            total++; if (rx_reset !== exp_rst) begin bad++; $display("FAIL rel_rx_reset cyc=%0d got=%0b exp=%0b", i, rx_reset, exp_rst); end
            total++; if (rx_out !== 1'b0) begin bad++; $display("FAIL rel_rx_out cyc=%0d got=%0b exp=0", i, rx_out); end
        end
        total++; if (hi !== R) begin bad++; $display("FAIL rel_pulse_len got=%0d exp=%0d", hi, R); end
        rx_in = 4'b0001;
        k = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            k++;
            if (rx_out === 1'b1) break;
        end
        total++; if (k !== 5) begin bad++; $display("FAIL pin_latency got=%0d exp=5", k); end
    endtask

    task automatic test_glitch();
        int hi;
        rx_in = '0;
        repeat (8) @(negedge clk);
        rx_in = 4'b0001;
        @(negedge clk);
        rx_in = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++; if (rx_out !== 1'b0) begin bad++; $display("FAIL glitch1 cyc=%0d got=%0b exp=0", i, rx_out); end
        end
        rx_in = 4'b0001;
        @(negedge clk);
        total++; if (rx_out !== exp_out) begin bad++; $display("FAIL glitch2_model got=%0b exp=%0b", rx_out, exp_out); end
        @(negedge clk);
        rx_in = '0;
        hi = 0;
        for (int i = 0; i < 12; i++) begin
            if (rx_out === 1'b1) hi++;
            total++; if (rx_out !== exp_out) begin bad++; $display("FAIL glitch2_model cyc=%0d got=%0b exp=%0b", i, rx_out, exp_out); end
            @(negedge clk);
        end
        total++; if (hi !== 2) begin bad++; $display("FAIL glitch2_width got=%0d exp=2", hi); end
    endtask

    task automatic test_random_pin();
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            total++; if (rx_out !== exp_out) begin bad++; $display("FAIL rand_pin cyc=%0d got=%0b exp=%0b", i, rx_out, exp_out); end
            if ($urandom_range(0, 2) == 0) rx_in = CH'($urandom_range(0, 15));
        end
    endtask

    task automatic test_channel_select();
        int hi;
        rx_in = 4'b0100;
        channel_select = 3'd2;
        hi = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (rx_reset === 1'b1) begin
                hi++;
                total++; if (rx_out !== 1'b0) begin bad++; $display("FAIL sel_gate cyc=%0d got=%0b exp=0", i, rx_out); end
            end
            total++; if (rx_reset !== exp_rst) begin bad++; $display("FAIL sel_rx_reset cyc=%0d got=%0b exp=%0b", i, rx_reset, exp_rst); end
        end
        total++; if (hi !== R) begin bad++; $display("FAIL sel_pulse_len got=%0d exp=%0d", hi, R); end
        total++; if (rx_out !== 1'b1) begin bad++; $display("FAIL sel_ch2_high got=%0b exp=1", rx_out); end
        rx_in = 4'b1011;
        repeat (8) @(negedge clk);
        total++; if (rx_out !== 1'b0) begin bad++; $display("FAIL sel_ch2_only got=%0b exp=0", rx_out); end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            total++; if (rx_out !== exp_out) begin bad++; $display("FAIL sel_ch2_rand cyc=%0d got=%0b exp=%0b", i, rx_out, exp_out); end
            if ($urandom_range(0, 2) == 0) rx_in = CH'($urandom_range(0, 15));
        end
        channel_select = 3'd5;
        rx_in = 4'b0001;
        repeat (24) @(negedge clk);
        total++; if (rx_out !== 1'b1) begin bad++; $display("FAIL sel5_ch0_high got=%0b exp=1", rx_out); end
        rx_in = 4'b1110;
        repeat (8) @(negedge clk);
        total++; if (rx_out !== 1'b0) begin bad++; $display("FAIL sel5_ch0_low got=%0b exp=0", rx_out); end
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            total++; if (rx_out !== exp_out) begin bad++; $display("FAIL sel5_rand cyc=%0d got=%0b exp=%0b", i, rx_out, exp_out); end
            if ($urandom_range(0, 2) == 0) rx_in = CH'($urandom_range(0, 15));
        end
    endtask

    task automatic test_loopback();
        channel_select = '0;
        loopback = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            total++; if (rx_out !== exp_out) begin bad++; $display("FAIL lb_model cyc=%0d got=%0b exp=%0b", i, rx_out, exp_out); end
            if (i >= 18) begin
                total++; if (rx_out !== tx) begin bad++; $display("FAIL lb_delay cyc=%0d got=%0b exp=%0b", i, rx_out, tx); end
            end
            tx = ~tx;
        end
        rx_enable = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            total++; if (rx_out !== exp_out) begin bad++; $display("FAIL dis_model cyc=%0d got=%0b exp=%0b", i, rx_out, exp_out); end
            if (i >= 18) begin
                total++; if (rx_out !== 1'b0) begin bad++; $display("FAIL dis_zero cyc=%0d got=%0b exp=0", i, rx_out); end
            end
            tx = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic test_errors();
        int want [5] = '{1, 2, 3, 3, 3};
        rx_enable = 1'b1; loopback = 1'b0; tx = 1'b0; channel_select = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            total++; if (rx_reset !== exp_rst) begin bad++; $display("FAIL err_setup_rst cyc=%0d got=%0b exp=%0b", i, rx_reset, exp_rst); end
        end
        for (int p = 0; p < 5; p++) begin
            rx_error = 1'b1;
            @(negedge clk);
            rx_error = 1'b0;
            @(negedge clk);
            total++; if (error_count !== ECW'(want[p])) begin bad++; $display("FAIL err_sat pulse=%0d got=%0d exp=%0d", p, error_count, want[p]); end
            total++; if (error_count !== exp_err) begin bad++; $display("FAIL err_model pulse=%0d got=%0d exp=%0d", p, error_count, exp_err); end
            repeat (2) @(negedge clk);
        end
        rx_error = 1'b1;
        @(negedge clk);
        rx_error = 1'b0;
        error_count_clear = 1'b1;
        @(negedge clk);
        error_count_clear = 1'b0;
        total++; if (error_count !== '0) begin bad++; $display("FAIL err_clear_wins got=%0d exp=0", error_count); end
        @(negedge clk);
        total++; if (error_count !== '0) begin bad++; $display("FAIL err_clear_hold got=%0d exp=0", error_count); end
        rx_error = 1'b1;
        @(negedge clk);
        rx_error = 1'b0;
        @(negedge clk);
        total++; if (error_count !== ECW'(1)) begin bad++; $display("FAIL err_after_clear got=%0d exp=1", error_count); end
        channel_select = 3'd1;
        repeat (2) @(negedge clk);
        total++; if (rx_reset !== 1'b1) begin bad++; $display("FAIL err_in_reset_rst got=%0b exp=1", rx_reset); end
        rx_error = 1'b1;
        @(negedge clk);
        rx_error = 1'b0;
        repeat (4) @(negedge clk);
        total++; if (error_count !== ECW'(1)) begin bad++; $display("FAIL err_masked got=%0d exp=1", error_count); end
        repeat (16) @(negedge clk);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            total++; if (error_count !== exp_err) begin bad++; $display("FAIL err_rand cyc=%0d got=%0d exp=%0d", i, error_count, exp_err); end
            rx_error = 1'($urandom_range(0, 1));
            error_count_clear = ($urandom_range(0, 9) == 0);
        end
        rx_error = 1'b0;
        error_count_clear = 1'b0;
    endtask

    task automatic test_activity();
        int hi;
        rx_active = 1'b1;
        @(negedge clk);
        rx_active = 1'b0;
        total++; if (activity_led !== 1'b1) begin bad++; $display("FAIL act_rise got=%0b exp=1", activity_led); end
        hi = 1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (activity_led === 1'b1) hi++;
            total++; if (activity_led !== exp_led) begin bad++; $display("FAIL act_model cyc=%0d got=%0b exp=%0b", i, activity_led, exp_led); end
        end
        total++; if (hi !== AS) begin bad++; $display("FAIL act_width got=%0d exp=%0d", hi, AS); end
        rx_active = 1'b1;
        hi = 0;
        for (int i = 1; i <= 25; i++) begin
            @(negedge clk);
            if (activity_led === 1'b1) hi++;
            total++; if (activity_led !== exp_led) begin bad++; $display("FAIL act_retrig_model cyc=%0d got=%0b exp=%0b", i, activity_led, exp_led); end
            rx_active = (i == 5);
        end
        total++; if (hi !== 5 + AS) begin bad++; $display("FAIL act_retrig_width got=%0d exp=%0d", hi, 5 + AS); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            total++; if (rx_out !== exp_out) begin bad++; $display("FAIL b2b_rx_out cyc=%0d got=%0b exp=%0b", i, rx_out, exp_out); end
            total++; if (rx_reset !== exp_rst) begin bad++; $display("FAIL b2b_rx_reset cyc=%0d got=%0b exp=%0b", i, rx_reset, exp_rst); end
            total++; if (activity_led !== exp_led) begin bad++; $display("FAIL b2b_led cyc=%0d got=%0b exp=%0b", i, activity_led, exp_led); end
            total++; if (error_count !== exp_err) begin bad++; $display("FAIL b2b_err cyc=%0d got=%0d exp=%0d", i, error_count, exp_err); end
            if ($urandom_range(0, 2) == 0) rx_in = CH'($urandom_range(0, 15));
            tx        = 1'($urandom_range(0, 1));
            rx_active = ($urandom_range(0, 15) == 0);
            rx_error  = 1'($urandom_range(0, 1));
            error_count_clear = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 11) == 0) begin
                channel_select = SW'($urandom_range(0, 7));
                loopback       = 1'($urandom_range(0, 1));
                rx_enable      = ($urandom_range(0, 3) != 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_random_pin();
        test_channel_select();
        test_loopback();
        test_errors();
        test_activity();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/coax_rx_frontend.md
# coax_rx_frontend

Parametrised receive front end between the raw coax input pins and `coax_buffered_rx`. It replaces the fixed two-flop input synchroniser with a configurable multi-channel synchroniser, a majority-vote glitch filter, a source selector (pin / loopback / disabled) and a receiver-reset sequencer that fires on any configuration change. It also provides a stretched activity indicator and a saturating receive-error counter for the control block.

## Interface

Parameters:
- `CHANNELS`, 1: number of raw coax inputs; one is selected at a time.
- `SEL_WIDTH`, `CHANNELS > 1 ? $clog2(CHANNELS) : 1`: width of `channel_select`.
- `SYNC_STAGES`, 2: synchroniser flops per channel, ≥2.
- `FILTER_TAPS`, 3: majority-filter window, odd, ≥1; a value of 1 disables filtering.
- `RESET_CYCLES`, 16: `rx_reset` pulse length after a configuration change, ≥1.
- `ACTIVITY_STRETCH`, 1900000: `activity_led` hold time in clocks (~50 ms at 38 MHz).
- `ERROR_COUNT_WIDTH`, 8: error counter width.

Ports:
- `clk`  in  1  receive clock (38 MHz PLL output).
- `reset`  in  1  synchronous, active-high.
- `rx_in`  in  CHANNELS  raw asynchronous coax receive inputs.
- `tx`  in  1  transmitter serial output, already in the `clk` domain; used for loopback.
- `rx_enable`  in  1  0 = receiver input forced low.
- `loopback`  in  1  1 = feed `tx` instead of the selected pin.
- `channel_select`  in  SEL_WIDTH  selects the `rx_in` bit; out-of-range values select channel 0.
- `rx_out`  out  1  filtered serial stream to `coax_buffered_rx`.
- `rx_reset`  out  1  reset to `coax_buffered_rx`.
- `rx_active`  in  1  receiver active flag.
- `rx_error`  in  1  receiver error flag (level).
- `activity_led`  out  1  stretched activity.
- `error_count`  out  ERROR_COUNT_WIDTH  saturating count of `rx_error` rising edges.
- `error_count_clear`  in  1  single-cycle clear.

## Operation

- Synchroniser: every `rx_in` bit passes through its own `SYNC_STAGES` chain, initialised to 0.
- Mux: the synchronised bit indexed by `channel_select` feeds a `FILTER_TAPS`-bit shift register. The filter output is a registered majority vote over the window.
- Source select, registered: `rx_enable=0` selects 0. Otherwise `loopback=1` selects `tx` and bypasses the synchroniser and filter. Otherwise the filter output is selected.
- `rx_out` is forced to 0 whenever `rx_reset` is high.
- Configuration register holds {`rx_enable`, `loopback`, `channel_select`}:
  - It is loaded from the inputs during `reset`.
  - Any difference from the live inputs updates the register and loads the reset counter with `RESET_CYCLES`.
  - `rx_reset` is high while the counter is nonzero, or while `reset` is high.
- Reset sequencer states:
  - IDLE: counter = 0.
  - RESETTING: counter > 0, decrementing by 1 per cycle.
  - A configuration change during RESETTING reloads the counter to `RESET_CYCLES` (restart, no accumulation).
- Activity stretcher:
  - `rx_active=1` loads the stretch counter with `ACTIVITY_STRETCH`; otherwise the counter decrements toward 0.
  - `activity_led` is registered and equals (counter ≠ 0).
- Error counter:
  - Increments on an `rx_error` 0→1 edge detected in the previous-cycle register, and saturates at all-ones.
  - Edges are ignored while `rx_reset` is high.
  - When `error_count_clear` and an edge occur in the same cycle, clear wins and the result is 0.

## Timing

- Reset values:
  - `rx_out` = 0, `activity_led` = 0, `error_count` = 0.
  - `rx_reset` = 1 during `reset` and for `RESET_CYCLES` cycles after `reset` deasserts.
  - Synchroniser and filter registers = 0.
- Pin path latency, `rx_in` edge to `rx_out` edge: `SYNC_STAGES + (FILTER_TAPS+1)/2 + 1` clocks (defaults: 5), ±1 clock for asynchronous sampling.
- Loopback latency, `tx` to `rx_out`: 1 clock.
- Glitch rejection: input pulses of ≤ `(FILTER_TAPS-1)/2` clocks never reach `rx_out`.
- Configuration change sampled at edge N:
  - `rx_reset` rises at edge N+1 and stays high for exactly `RESET_CYCLES` cycles.
  - `rx_out` follows the new source from the first cycle after `rx_reset` falls.
- `activity_led` rises 1 clock after `rx_active` rises, and falls `ACTIVITY_STRETCH` clocks after the last cycle with `rx_active=1`.
- `error_count` updates 2 clocks after the `rx_error` rising edge (edge-detect register, then counter). Clear takes effect 1 clock after `error_count_clear`.

## Test plan

- Reset release with defaults:
  - `rx_reset` is high for 16 cycles after `reset` drops and all other outputs are 0.
  - A `rx_in` step 0→1 then appears on `rx_out` 5 clocks later.
- Glitch filter with `FILTER_TAPS=3`:
  - 1-clock high pulse on `rx_in` → `rx_out` stays 0.
  - 2-clock pulse → `rx_out` high for 2 clocks.
- `CHANNELS=4`:
  - Change `channel_select` 0→2 → 16-cycle `rx_reset` with `rx_out`=0; `rx_out` then follows `rx_in[2]` only.
  - `channel_select=5` with `SEL_WIDTH=3` → channel 0.
- Loopback:
  - `loopback=1`, toggle `tx` every cycle → after the reset pulse, `rx_out` equals `tx` delayed 1 clock.
  - `rx_enable=0` → `rx_out`=0 regardless of `tx`.
- Error counter, `ERROR_COUNT_WIDTH=2`:
  - 5 `rx_error` pulses → count 1,2,3,3,3.
  - Clear coincident with an edge → 0.
  - An edge during `rx_reset` → no increment.
- `ACTIVITY_STRETCH=10`:
  - 1-cycle `rx_active` → `activity_led` high for exactly 10 clocks.
  - Retrigger at clock 5 → held until 10 clocks after the retrigger.
